use_counter_banked: RTL and testbench
=====================================

# use_counter_banked

Parametrised, banked table of saturating confidence counters for the branch-prediction path. It is the generalised successor of the fixed 128-entry, 2-bank, 2-bit counter table. Counter width, table depth and bank count are set by parameters. It adds a registered read with a valid flag, write-to-read forwarding, and an attenuation engine that sweeps and halves every counter over multiple cycles.

## Interface
- CNT_WIDTH, 2: counter width in bits; must be ≥1.
- ADDR_WIDTH, 7: table depth is 2^ADDR_WIDTH entries.
- BANK_BITS, 1: number of banks is 2^BANK_BITS. The bank is selected by the address MSBs; index-in-bank is the low ADDR_WIDTH-BANK_BITS bits. Must satisfy BANK_BITS < ADDR_WIDTH.
- INIT_VALUE, 1: value loaded into every counter on reset; must be < 2^CNT_WIDTH.

Ports:
- Clk  in  1  sole clock; all logic on the rising edge.
- Rest  in  1  synchronous, active-high reset.
- Waddr  in  ADDR_WIDTH  update address.
- Wable  in  1  update enable.
- Wdate  in  1  update direction: 1 = increment (correct), 0 = decrement (fault).
- Raddr  in  ADDR_WIDTH  read address.
- Rable  in  1  read enable.
- Atten  in  1  single-cycle request to start an attenuation sweep.
- Rdate  out  CNT_WIDTH  registered read data.
- Rvalid  out  1  Rdate carries the result of the read issued the previous cycle.
- AttenBusy  out  1  attenuation sweep in progress.

## Operation
- Storage is 2^ADDR_WIDTH counters held in flops, organised as 2^BANK_BITS banks.
- **Update.** When Wable is high, the counter at Waddr takes cnt+1 if Wdate=1, or cnt-1 if Wdate=0.
  - The counter saturates at 2^CNT_WIDTH-1 and at 0.
  - No wrap-around under any input sequence.
- **Read.** When Rable is high, Rdate is loaded at the clock edge with the next-state value of entry Raddr, and Rvalid is set to 1.
  - The next-state value includes any update and any attenuation applied at the same edge (write-to-read forwarding).
  - When Rable is low, Rvalid goes to 0 and Rdate holds its previous value.
- **Attenuation FSM.** Two states: IDLE and SWEEP.
  - IDLE → SWEEP when Atten=1. The sweep index is cleared to 0.
  - In SWEEP, each cycle, the entry at the sweep index in every bank is replaced by cnt>>1.
  - The index increments each cycle. SWEEP → IDLE after the cycle that processes index 2^(ADDR_WIDTH-BANK_BITS)-1.
  - Atten is ignored while in SWEEP; there is no queueing.
- **Update/attenuation collision.** If Wable targets an entry being attenuated in the same cycle, the update is applied to the stored (un-halved) value, and halving of that entry is skipped for this sweep.
- Reads and updates are accepted every cycle, including during a sweep. The block never stalls its requesters.
- **Reset.** When Rest=1, the following happen at the edge:
  - All counters are set to INIT_VALUE.
  - The FSM returns to IDLE and the sweep index goes to 0.
  - Rdate=0, Rvalid=0, AttenBusy=0.
  - Reset overrides Wable, Rable and Atten in the same cycle, and aborts any sweep in progress.

## Timing
- Update latency: 1 cycle. The new value is stored at the edge that samples Wable.
- Read latency: 1 cycle. Request at edge t produces Rdate/Rvalid valid after edge t.
- Attenuation:
  - Atten sampled at edge t.
  - AttenBusy is high after edges t+1 through t+N, where N = 2^(ADDR_WIDTH-BANK_BITS); N = 64 with the defaults.
  - Index i is halved at edge t+1+i.
  - AttenBusy falls after edge t+N+1.
  - The earliest accepted new Atten is at edge t+N+1.
- AttenBusy is a decode of the registered FSM state only. There is no combinational path from any input to any output.

## Test plan
- Reset, then read addr 0 and addr 127 → Rdate=1, Rvalid=1 one cycle after each read; Rvalid=0 on idle cycles.
- Four increments to addr 5, then read → 3 (saturated). Five decrements, then read → 0 (no wrap).
- Same cycle: Wable=1, Wdate=1, Waddr=70 and Rable=1, Raddr=70, starting from INIT 1 → Rdate=2 next cycle (forwarded).
- Preload addr 3=3, addr 67=2, addr 10=1, then pulse Atten → AttenBusy high for exactly 64 cycles. Afterwards: addr3=1, addr67=1, addr10=0; untouched entries 1→0. A second Atten pulsed mid-sweep has no effect.
- Collision: addr 7=3; pulse Atten at edge t, and at edge t+8 (index 7) issue a decrement to addr 7 → addr7=2 after the sweep (halving skipped). Decrement at edge t+20 instead → addr7=0 (halved at t+8 to 1, then decremented).
- Assert Rest at edge t+30 of a sweep → AttenBusy=0 and all entries read back 1. A new Atten is accepted on the next cycle.

Source files
------------

// File: rtl/use_counter_banked.sv
// -----------------------------------------------------------------------------
// use_counter_banked
//
// Banked table of saturating confidence counters for branch prediction.
// Counter width, depth and bank count are set by parameters. The table supports
// one update and one read per cycle, never stalls, and forwards the
// same-edge next-state value to the read port. An attenuation engine walks
// the in-bank index once, halving the entry at that index in every bank
// each cycle.
//
// Ports:
//   Clk        in   1           sole clock, rising edge
//   Rest       in   1           synchronous active-high reset
//   Waddr      in   ADDR_WIDTH  update address
//   Wable      in   1           update enable
//   Wdate      in   1           1 = increment, 0 = decrement
//   Raddr      in   ADDR_WIDTH  read address
//   Rable      in   1           read enable
//   Atten      in   1           pulse to start an attenuation sweep
//   Rdate      out  CNT_WIDTH   registered read data
//   Rvalid     out  1           Rdate holds the read issued last cycle
//   AttenBusy  out  1           sweep in progress (registered)
// -----------------------------------------------------------------------------
module use_counter_banked #(
  parameter int CNT_WIDTH  = 2,
  parameter int ADDR_WIDTH = 7,
  parameter int BANK_BITS  = 1,
  parameter int INIT_VALUE = 1
) (
  input  logic                  Clk,
  input  logic                  Rest,
  input  logic [ADDR_WIDTH-1:0] Waddr,
  input  logic                  Wable,
  input  logic                  Wdate,
  input  logic [ADDR_WIDTH-1:0] Raddr,
  input  logic                  Rable,
  input  logic                  Atten,
  output logic [CNT_WIDTH-1:0]  Rdate,
  output logic                  Rvalid,
  output logic                  AttenBusy
);

  localparam int DEPTH     = 1 << ADDR_WIDTH;
  localparam int IDX_W     = ADDR_WIDTH - BANK_BITS;
  localparam int NUM_BANKS = 1 << BANK_BITS;

  localparam logic [IDX_W-1:0]     IDX_LAST = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'(INIT_VALUE);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t               state_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 busy_q;

  logic [CNT_WIDTH-1:0] cnt_q [DEPTH];
  logic [CNT_WIDTH-1:0] cnt_d [DEPTH];

  logic [CNT_WIDTH-1:0] rdate_q, rdate_d;
  logic                 rvalid_q, rvalid_d;

  logic [CNT_WIDTH-1:0] wr_cur;
  logic [CNT_WIDTH-1:0] wr_new;

  // Full table address of the entry being attenuated in each bank: the bank
  // number sits in the address MSBs, the sweep index in the low bits.
  logic [ADDR_WIDTH-1:0] att_addr [NUM_BANKS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      assign att_addr[gi] = {BANK_BITS'(gi), idx_q};
    end
  endgenerate

  // Saturating update of the stored value at Waddr.
  always_comb begin
    wr_cur = cnt_q[Waddr];
    wr_new = wr_cur;
    if (Wdate) begin
      if (wr_cur != CNT_MAX) wr_new = wr_cur + CNT_WIDTH'(1);
    end else begin
      if (wr_cur != '0) wr_new = wr_cur - CNT_WIDTH'(1);
    end
  end

  // Next-state table. Halving is applied first and the update afterwards, so
  // a colliding update lands on the un-halved stored value and the halving of
  // that entry is simply lost for this sweep (each index is visited once).
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      cnt_d[e] = cnt_q[e];
    end
    if (state_q == SWEEP) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        cnt_d[att_addr[b]] = cnt_q[att_addr[b]] >> 1;
      end
    end
    if (Wable) begin
      cnt_d[Waddr] = wr_new;
    end
  end

  // Read returns the next-state value, giving write/attenuation forwarding.
  always_comb begin
    rvalid_d = Rable;
    rdate_d  = rdate_q;
    if (Rable) rdate_d = cnt_d[Raddr];
  end

  always_ff @(posedge Clk) begin
    if (Rest) begin
      for (int e = 0; e < DEPTH; e++) begin
        cnt_q[e] <= CNT_INIT;
      end
      rdate_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      rdate_q  <= rdate_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Attenuation FSM. AttenBusy is the state delayed by one register so that
  // it is high for exactly the N cycles following the first halving edge.
  always_ff @(posedge Clk) begin
    if (Rest) begin
      state_q <= IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      busy_q <= (state_q == SWEEP);
      case (state_q)
        IDLE: begin
          if (Atten) begin
            state_q <= SWEEP;
            idx_q   <= '0;
          end
        end
        SWEEP: begin
          idx_q <= idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Rdate     = rdate_q;
  assign Rvalid    = rvalid_q;
  assign AttenBusy = busy_q;

endmodule

// File: tb/tb_use_counter_banked.sv
// -----------------------------------------------------------------------------
// tb_use_counter_banked
//
// Directed bench for use_counter_banked with default parameters (2-bit
// counters, 128 entries, 2 banks of 64). Expected read data is queued when a
// read is issued and popped when Rvalid is sampled one cycle later.
// -----------------------------------------------------------------------------
module tb_use_counter_banked;

  logic       Clk;
  logic       Rest;
  logic [6:0] Waddr;
  logic       Wable;
  logic       Wdate;
  logic [6:0] Raddr;
  logic       Rable;
  logic       Atten;
  logic [1:0] Rdate;
  logic       Rvalid;
  logic       AttenBusy;

  int total;
  int bad;
  int busy_cnt;
  logic [31:0] exp_q [$];

  use_counter_banked dut (
    .Clk       (Clk),
    .Rest      (Rest),
    .Waddr     (Waddr),
    .Wable     (Wable),
    .Wdate     (Wdate),
    .Raddr     (Raddr),
    .Rable     (Rable),
    .Atten     (Atten),
    .Rdate     (Rdate),
    .Rvalid    (Rvalid),
    .AttenBusy (AttenBusy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One clock cycle with the given inputs; checks Rvalid and, for a read,
  // pops and compares the queued expectation after the edge.
  task automatic cyc(input bit we, input bit wd, input int wa,
                     input bit re, input int ra, input bit at, input int exp);
    logic [31:0] e;
    Wable = we; Wdate = wd; Waddr = 7'(wa);
    Rable = re; Raddr = 7'(ra); Atten = at;
    if (re) exp_q.push_back(32'(exp));
    @(posedge Clk); #1;
    chk("rvalid", 32'(Rvalid), 32'(re));
    if (re) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_empty", 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("rdate@%0d", ra), 32'(Rdate), e);
      end
    end
    Wable = 0; Wdate = 0; Rable = 0; Atten = 0;
  endtask

  task automatic rd(input int a, input int exp);
    cyc(0, 0, 0, 1, a, 0, exp);
  endtask

  task automatic wr(input int a, input bit dir);
    cyc(1, dir, a, 0, 0, 0, 0);
  endtask

  int addrs [7] = '{0, 127, 5, 70, 3, 67, 10};
  int vals  [7] = '{0, 0,   0, 1,  1, 1,  0};

  initial begin
    total = 0; bad = 0;
    Rest = 1; Wable = 0; Wdate = 0; Waddr = 0; Raddr = 0; Rable = 0; Atten = 0;
    repeat (2) @(posedge Clk);
    #1;
    chk("reset_rdate", 32'(Rdate), 0);
    chk("reset_rvalid", 32'(Rvalid), 0);
    chk("reset_busy", 32'(AttenBusy), 0);
    Rest = 0;

    // Initial contents and Rvalid behaviour on idle cycles.
    rd(0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    rd(127, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Saturation at both ends.
    repeat (4) wr(5, 1);
    rd(5, 3);
    repeat (5) wr(5, 0);
    rd(5, 0);

    // Same-cycle update and read are forwarded.
    cyc(1, 1, 70, 1, 70, 0, 2);

    // Preload then a full sweep; a second Atten mid-sweep is ignored.
    wr(3, 1); wr(3, 1);
    wr(67, 1);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("busy_after_t", 32'(AttenBusy), 0);
    busy_cnt = 0;
    for (int k = 1; k <= 66; k++) begin
      cyc(0, 0, 0, 0, 0, (k == 30), 0);
      chk($sformatf("busy_k%0d", k), 32'(AttenBusy), 32'(k <= 64));
      if (AttenBusy === 1'b1) busy_cnt++;
    end
    chk("busy_cycles", 32'(busy_cnt), 64);
    for (int i = 0; i < 7; i++) rd(addrs[i], vals[i]);

    // Collision at index 7: halving is skipped.
    repeat (3) wr(7, 1);
    cyc(0, 0, 0, 0, 0, 1, 0);
    for (int k = 1; k <= 66; k++) cyc((k == 8), 0, 7, 0, 0, 0, 0);
    rd(7, 2);

    // Decrement after index 7 was halved.
    wr(7, 1);
    cyc(0, 0, 0, 0, 0, 1, 0);
    for (int k = 1; k <= 66; k++) cyc((k == 20), 0, 7, 0, 0, 0, 0);
    rd(7, 0);

    // Reset mid-sweep overrides all requests in that cycle.
    cyc(0, 0, 0, 0, 0, 1, 0);
    for (int k = 1; k <= 29; k++) cyc(0, 0, 0, 0, 0, 0, 0);
    Rest = 1; Wable = 1; Wdate = 1; Waddr = 0; Rable = 1; Raddr = 5; Atten = 1;
    @(posedge Clk); #1;
    chk("midreset_busy", 32'(AttenBusy), 0);
    chk("midreset_rvalid", 32'(Rvalid), 0);
    chk("midreset_rdate", 32'(Rdate), 0);
    Rest = 0; Wable = 0; Wdate = 0; Rable = 0; Atten = 0;

    // New Atten accepted right after reset; entry 127 (last index) stays 1
    // until the final sweep edge, where the halved value is forwarded.
    cyc(0, 0, 0, 0, 0, 1, 0);
    for (int k = 1; k <= 66; k++) begin
      cyc(0, 0, 0, (k <= 64), 127, 0, (k == 64) ? 0 : 1);
      chk($sformatf("busy2_k%0d", k), 32'(AttenBusy), 32'(k <= 64));
    end
    // Every entry was 1 after reset, so one sweep leaves them all at 0.
    for (int a = 0; a < 128; a++) rd(a, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
